// File: rtl/zip_pkg.sv
// Shared types and constants for the zip sample-scheduling blocks.
package zip_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        PAD  = 2'd2
    } zip_sched_state_t;

    localparam int ZIP_GROUP_DEFAULT = 4;
    localparam int ZIP_MAX_REQ       = 4;

    function automatic int zip_wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/zip_rr_scheduler_if.sv
// Scheduler bus: per-requester AXI-Stream sinks plus one AXI-Stream source to the compressor.
// master = scheduler side, slave = sources/compressor side.
interface zip_rr_scheduler_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ*WIDTH-1:0] s_tdata;
    logic [NUM_REQ-1:0]       s_tlast;
    logic [NUM_REQ-1:0]       s_tvalid;
    logic [NUM_REQ-1:0]       s_tready;
    logic [WIDTH-1:0]         m_tdata;
    logic                     m_tlast;
    logic                     m_tvalid;
    logic                     m_tready;
    logic [IDX_W-1:0]         m_chan;

    modport master (
        input  s_tdata, s_tlast, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tlast, m_tvalid, m_chan
    );

    modport slave (
        output s_tdata, s_tlast, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tlast, m_tvalid, m_chan
    );

endinterface

// File: rtl/zip_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, modulo N.
module zip_rr_pick #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
)(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int pos;

    // Scan from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        idx = '0;
        pos = 0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = (int'(ptr) + i) % N;
            if (req[IDX_W'(pos)]) idx = IDX_W'(pos);
        end
    end

    assign any = |req;

endmodule

// File: rtl/zip_rr_scheduler.sv
// Packet round-robin scheduler in front of the 4-sample IQ compressor; pads short packets to GROUP.
// Optional ZIP_SCHED_STATS_EN adds per-requester packet counters and a padded-packet counter.
module zip_rr_scheduler
    import zip_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2,
    parameter int GROUP   = ZIP_GROUP_DEFAULT
)(
    input  logic clk,
    input  logic reset_n,
    zip_rr_scheduler_if.master bus
`ifdef ZIP_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] pkt_cnt,
    output logic [15:0]           pad_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (GROUP > 1) ? $clog2(GROUP) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(GROUP - 1);

    zip_sched_state_t state, state_nxt;
    logic [IDX_W-1:0] grant, grant_nxt, rr_ptr, rr_ptr_nxt, pick_idx;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt, pad_rem, pad_rem_nxt;
    logic             pick_any, hs, pkt_done;

    zip_rr_pick #(.N(NUM_REQ)) u_pick (
        .req (bus.s_tvalid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign hs       = bus.m_tvalid & bus.m_tready;
    assign pkt_done = hs & bus.m_tlast;

    // Datapath muxing; IDLE leaves everything at the quiet defaults.
    always_comb begin
        bus.s_tready = '0;
        bus.m_tvalid = 1'b0;
        bus.m_tlast  = 1'b0;
        bus.m_tdata  = '0;
        bus.m_chan   = grant;
        case (state)
            PASS: begin
                bus.m_tdata         = bus.s_tdata[grant*WIDTH +: WIDTH];
                bus.m_tvalid        = bus.s_tvalid[grant];
                bus.m_tlast         = bus.s_tlast[grant] && (beat_cnt == LAST_BEAT);
                bus.s_tready[grant] = bus.m_tready;
            end
            PAD: begin
                bus.m_tvalid = 1'b1;
                bus.m_tlast  = (pad_rem == CNT_W'(1));
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        pad_rem_nxt  = pad_rem;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_nxt    = pick_idx;
                    beat_cnt_nxt = '0;
                    state_nxt    = PASS;
                end
            end
            PASS: begin
                if (hs) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                    if (bus.s_tlast[grant]) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state_nxt = IDLE;
                        end else begin
                            pad_rem_nxt = LAST_BEAT - beat_cnt;
                            state_nxt   = PAD;
                        end
                    end
                end
            end
            PAD: begin
                if (hs) begin
                    pad_rem_nxt = pad_rem - 1'b1;
                    if (pad_rem == CNT_W'(1)) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (pkt_done) rr_ptr_nxt = IDX_W'(zip_wrap_inc(int'(grant), NUM_REQ));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            pad_rem  <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
            pad_rem  <= pad_rem_nxt;
        end
    end

`ifdef ZIP_SCHED_STATS_EN
    logic                     pad_start;
    logic [NUM_REQ-1:0][15:0] pkt_q;

    // A packet is counted as padded at the moment its short tail is accepted.
    assign pad_start = (state == PASS) && hs && bus.s_tlast[grant] && (beat_cnt != LAST_BEAT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_q   <= '0;
            pad_cnt <= '0;
        end else begin
            if (pkt_done)  pkt_q[grant] <= pkt_q[grant] + 16'd1;
            if (pad_start) pad_cnt      <= pad_cnt + 16'd1;
        end
    end

    assign pkt_cnt = pkt_q;
`endif

endmodule

// File: tb/tb_zip_rr_scheduler.sv
// Directed bench for zip_rr_scheduler (NUM_REQ=3, GROUP=4) with queue-fed sources and an output log.
module tb_zip_rr_scheduler;
    localparam int NR = 3;
    localparam int W  = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    zip_rr_scheduler_if #(.WIDTH(W), .NUM_REQ(NR)) bus();
`ifdef ZIP_SCHED_STATS_EN
    logic [NR*16-1:0] pkt_cnt;
    logic [15:0]      pad_cnt;
`endif

    zip_rr_scheduler #(.WIDTH(W), .NUM_REQ(NR), .GROUP(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef ZIP_SCHED_STATS_EN
        ,
        .pkt_cnt (pkt_cnt),
        .pad_cnt (pad_cnt)
`endif
    );

    typedef struct { logic [31:0] d; logic l; } beat_t;
    typedef struct { logic [31:0] d; logic l; logic [1:0] c; int cyc; } obs_t;

    beat_t       srcq[NR][$];
    obs_t        outq[$];
    int          hold[NR];
    int          cyc, checks, errors;
    bit          tog;
    logic        prev_stall;
    logic [31:0] prev_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            if (srcq[k].size() > 0 && hold[k] == 0) begin
                bus.s_tvalid[k]        = 1'b1;
                bus.s_tdata[k*W +: W]  = srcq[k][0].d;
                bus.s_tlast[k]         = srcq[k][0].l;
            end else begin
                bus.s_tvalid[k]        = 1'b0;
                bus.s_tdata[k*W +: W]  = '0;
                bus.s_tlast[k]         = 1'b0;
            end
        end
    endtask

    task automatic pushb(input int k, input logic [31:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        srcq[k].push_back(b);
        drive();
    endtask

    task automatic push(input int k, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) pushb(k, base + 32'(i), (i == n - 1));
    endtask

    // One clock: observe at the falling edge, then advance sources just after the rising edge.
    task automatic tick();
        logic [NR-1:0] shs;
        obs_t o;
        @(negedge clk);
        if (prev_stall) begin
            check("stall_valid", 64'(bus.m_tvalid), 64'd1);
            check("stall_data", 64'(bus.m_tdata), 64'(prev_data));
        end
        prev_stall = bus.m_tvalid & ~bus.m_tready & reset_n;
        prev_data  = bus.m_tdata;
        if (bus.m_tvalid & bus.m_tready) begin
            o.d = bus.m_tdata; o.l = bus.m_tlast; o.c = bus.m_chan; o.cyc = cyc;
            outq.push_back(o);
        end
        shs = bus.s_tvalid & bus.s_tready;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NR; k++) begin
            if (shs[k]) void'(srcq[k].pop_front());
            if (hold[k] > 0) hold[k]--;
        end
        drive();
        bus.m_tready = tog ? ~bus.m_tready : 1'b1;
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int t = 0;
        while (outq.size() < n && t < budget) begin
            tick();
            t++;
        end
        check($sformatf("%s_count", tag), 64'(outq.size()), 64'(n));
    endtask

    task automatic chk_beat(input string tag, input int i, input logic [1:0] c,
                            input logic [31:0] d, input logic l);
        logic [63:0] o;
        if (i < outq.size()) o = {29'd0, outq[i].c, outq[i].l, outq[i].d};
        else                 o = '1;
        check($sformatf("%s_beat%0d", tag, i), o, {29'd0, c, l, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; tog = 1'b0; prev_stall = 1'b0; prev_data = '0;
        for (int k = 0; k < NR; k++) hold[k] = 0;
        bus.m_tready = 1'b1;
        drive();

        // Reset state with two sources already valid; two 8-beat packets each.
        for (int p = 0; p < 2; p++) begin
            push(0, 8, 32'(p) << 20);
            push(1, 8, (32'd1 << 28) | (32'(p) << 20));
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
        check("rst_m_tlast",  64'(bus.m_tlast),  64'd0);
        check("rst_m_tdata",  64'(bus.m_tdata),  64'd0);
        check("rst_m_chan",   64'(bus.m_chan),   64'd0);
        check("rst_s_tready", 64'(bus.s_tready), 64'd0);
        reset_n = 1'b1;

        // Alternating grants 0,1,0,1 with one bubble between packets.
        outq.delete();
        wait_beats(32, 200, "t1");
        for (int i = 0; i < 32; i++) begin
            int n, k, p, b;
            n = i / 8; k = n % 2; p = n / 2; b = i % 8;
            chk_beat("t1", i, 2'(k), (32'(k) << 28) | (32'(p) << 20) | 32'(b), (b == 7));
        end
        check("t1_first_lat", 64'(outq[0].cyc), 64'd1);
        check("t1_no_bubble", 64'(outq[7].cyc - outq[0].cyc), 64'd7);
        check("t1_one_bubble", 64'(outq[8].cyc - outq[7].cyc), 64'd2);

        // 5-beat packet from requester 1 padded to 8.
        outq.delete();
        for (int n = 1; n <= 5; n++) pushb(1, {16'(n * 32'h1000), 16'(n * 32'h1000)}, (n == 5));
        wait_beats(8, 100, "t2");
        for (int i = 0; i < 8; i++)
            chk_beat("t2", i, 2'd1, (i < 5) ? {16'((i + 1) * 32'h1000), 16'((i + 1) * 32'h1000)} : 32'd0,
                     (i == 7));
`ifdef ZIP_SCHED_STATS_EN
        check("t2_pad_cnt", 64'(pad_cnt), 64'd1);
        check("t2_pkt_cnt", 64'(pkt_cnt), 64'h0000_0003_0002);
`endif

        // Ready toggling through PASS and PAD; rr_ptr=2 picks 2 over 0; 1-beat packet gets 3 pads.
        outq.delete();
        tog = 1'b1;
        push(2, 6, 32'h2030_0000);
        pushb(0, 32'hCAFE_0001, 1'b1);
        wait_beats(12, 100, "t3");
        tog = 1'b0;
        bus.m_tready = 1'b1;
        for (int i = 0; i < 6; i++) chk_beat("t3", i, 2'd2, 32'h2030_0000 + 32'(i), 1'b0);
        chk_beat("t3", 6, 2'd2, 32'd0, 1'b0);
        chk_beat("t3", 7, 2'd2, 32'd0, 1'b1);
        chk_beat("t3", 8, 2'd0, 32'hCAFE_0001, 1'b0);
        for (int i = 9; i < 12; i++) chk_beat("t3", i, 2'd0, 32'd0, (i == 11));
`ifdef ZIP_SCHED_STATS_EN
        check("t3_pad_cnt", 64'(pad_cnt), 64'd3);
        check("t3_pkt_cnt", 64'(pkt_cnt), 64'h0001_0003_0003);
`endif

        // rr_ptr=1 with requesters 2 and 0: grant 2 then 0, pointer wraps back to 1.
        outq.delete();
        push(0, 4, 32'h0040_0000);
        push(2, 4, 32'h2040_0000);
        wait_beats(8, 60, "t4a");
        for (int i = 0; i < 4; i++) chk_beat("t4a", i, 2'd2, 32'h2040_0000 + 32'(i), (i == 3));
        for (int i = 4; i < 8; i++) chk_beat("t4a", i, 2'd0, 32'h0040_0000 + 32'(i - 4), (i == 7));
        outq.delete();
        push(0, 4, 32'h0041_0000);
        push(1, 4, 32'h1041_0000);
        wait_beats(8, 60, "t4b");
        for (int i = 0; i < 4; i++) chk_beat("t4b", i, 2'd1, 32'h1041_0000 + 32'(i), (i == 3));
        for (int i = 4; i < 8; i++) chk_beat("t4b", i, 2'd0, 32'h0041_0000 + 32'(i - 4), (i == 7));

        // Reset in the middle of a packet.
        outq.delete();
        push(1, 8, 32'h1050_0000);
        wait_beats(3, 50, "t5a");
        reset_n = 1'b0;
        #1;
        check("t5_rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
        check("t5_rst_s_tready", 64'(bus.s_tready), 64'd0);
        check("t5_rst_m_tlast",  64'(bus.m_tlast),  64'd0);
`ifdef ZIP_SCHED_STATS_EN
        check("t5_rst_pad_cnt", 64'(pad_cnt), 64'd0);
        check("t5_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
        srcq[1].delete();
        prev_stall = 1'b0;
        drive();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        outq.delete();
        push(1, 4, 32'h1051_0000);
        push(0, 4, 32'h0051_0000);
        wait_beats(8, 60, "t5b");
        for (int i = 0; i < 4; i++) chk_beat("t5b", i, 2'd0, 32'h0051_0000 + 32'(i), (i == 3));
        for (int i = 4; i < 8; i++) chk_beat("t5b", i, 2'd1, 32'h1051_0000 + 32'(i - 4), (i == 7));

        // Granted source stalls 10 cycles; requester 1 must wait for the packet's end.
        outq.delete();
        push(0, 8, 32'h0060_0000);
        wait_beats(3, 50, "t6a");
        hold[0] = 10;
        push(1, 4, 32'h1060_0000);
        #1;
        check("t6_stall_m_tvalid", 64'(bus.m_tvalid), 64'd0);
        check("t6_stall_s_tready", 64'(bus.s_tready), 64'b001);
        wait_beats(12, 100, "t6b");
        for (int i = 0; i < 8; i++) chk_beat("t6", i, 2'd0, 32'h0060_0000 + 32'(i), (i == 7));
        for (int i = 8; i < 12; i++) chk_beat("t6", i, 2'd1, 32'h1060_0000 + 32'(i - 8), (i == 11));
        check("t6_gap", 64'(outq[3].cyc - outq[2].cyc), 64'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
